// File: rtl/vx_issue_scoreboard.sv
// Issue scoreboard: holds decoded instructions until their registers are free.
// Optional stall counter port perf_stalls enabled by VX_SCOREBOARD_PERF_EN.
module vx_issue_scoreboard #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64,
    parameter int PAYLOAD_W = 128,
    parameter int PERF_W    = 44,
    parameter int WIS_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NR_W      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ibuf_valid,
    input  logic [WIS_W-1:0]     ibuf_wis,
    input  logic                 ibuf_wb,
    input  logic [NR_W-1:0]      ibuf_rd,
    input  logic [NR_W-1:0]      ibuf_rs1,
    input  logic [NR_W-1:0]      ibuf_rs2,
    input  logic [NR_W-1:0]      ibuf_rs3,
    input  logic [PAYLOAD_W-1:0] ibuf_payload,
    output logic                 ibuf_ready,

    input  logic                 wb_valid,
    input  logic [WIS_W-1:0]     wb_wis,
    input  logic [NR_W-1:0]      wb_rd,
    input  logic                 wb_eop,

    output logic                 sb_valid,
    output logic [WIS_W-1:0]     sb_wis,
    output logic                 sb_wb,
    output logic [NR_W-1:0]      sb_rd,
    output logic [NR_W-1:0]      sb_rs1,
    output logic [NR_W-1:0]      sb_rs2,
    output logic [NR_W-1:0]      sb_rs3,
    output logic [PAYLOAD_W-1:0] sb_payload,
    input  logic                 sb_ready
`ifdef VX_SCOREBOARD_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_stalls
`endif
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0]                busy_row;
    logic                               raw;
    logic                               waw;
    logic                               hazard;
    logic                               fire;

    // Hazard check against the registered table only; a writeback
    // landing this cycle is seen one cycle later.
    always_comb begin
        busy_row   = busy[ibuf_wis];
        raw        = busy_row[ibuf_rs1]
                   | busy_row[ibuf_rs2]
                   | busy_row[ibuf_rs3];
        waw        = ibuf_wb & busy_row[ibuf_rd];
        hazard     = ibuf_valid & (raw | waw);
        ibuf_ready = !hazard && (!sb_valid || sb_ready);
        fire       = ibuf_valid && ibuf_ready;
    end

    // Next busy table: final writeback clears, issue sets; set applied
    // last so it wins on a collision. r0 is never marked.
    always_comb begin
        busy_next = busy;
        if (wb_valid && wb_eop) begin
            busy_next[wb_wis][wb_rd] = 1'b0;
        end
        if (fire && ibuf_wb && (ibuf_rd != '0)) begin
            busy_next[ibuf_wis][ibuf_rd] = 1'b1;
        end
    end

    // Busy table register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Output register: load on accept, hold under backpressure,
    // drop valid once consumed with nothing new behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid   <= 1'b0;
            sb_wis     <= '0;
            sb_wb      <= 1'b0;
            sb_rd      <= '0;
            sb_rs1     <= '0;
            sb_rs2     <= '0;
            sb_rs3     <= '0;
            sb_payload <= '0;
        end else if (fire) begin
            sb_valid   <= 1'b1;
            sb_wis     <= ibuf_wis;
            sb_wb      <= ibuf_wb;
            sb_rd      <= ibuf_rd;
            sb_rs1     <= ibuf_rs1;
            sb_rs2     <= ibuf_rs2;
            sb_rs3     <= ibuf_rs3;
            sb_payload <= ibuf_payload;
        end else if (sb_ready) begin
            sb_valid   <= 1'b0;
        end
    end

`ifdef VX_SCOREBOARD_PERF_EN
    // Saturating count of cycles an instruction waits on a hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (hazard && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + 1'b1;
        end
    end
`else
    logic unused_perf_w;
    assign unused_perf_w = (PERF_W != 0);
`endif

    // A final writeback must release a register that was marked busy.
    always @(posedge clk) begin
        if (!reset && wb_valid && wb_eop) begin
            assert (busy[wb_wis][wb_rd]);
        end
    end

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Bench for vx_issue_scoreboard: vector table, output scoreboard,
// reset and perf sequences.
module tb_vx_issue_scoreboard;

    logic         clk;
    logic         reset;
    logic         ibuf_valid;
    logic [1:0]   ibuf_wis;
    logic         ibuf_wb;
    logic [5:0]   ibuf_rd;
    logic [5:0]   ibuf_rs1;
    logic [5:0]   ibuf_rs2;
    logic [5:0]   ibuf_rs3;
    logic [127:0] ibuf_payload;
    logic         ibuf_ready;
    logic         wb_valid;
    logic [1:0]   wb_wis;
    logic [5:0]   wb_rd;
    logic         wb_eop;
    logic         sb_valid;
    logic [1:0]   sb_wis;
    logic         sb_wb;
    logic [5:0]   sb_rd;
    logic [5:0]   sb_rs1;
    logic [5:0]   sb_rs2;
    logic [5:0]   sb_rs3;
    logic [127:0] sb_payload;
    logic         sb_ready;
`ifdef VX_SCOREBOARD_PERF_EN
    logic [43:0]  perf_stalls;
`endif

    vx_issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .ibuf_valid   (ibuf_valid),
        .ibuf_wis     (ibuf_wis),
        .ibuf_wb      (ibuf_wb),
        .ibuf_rd      (ibuf_rd),
        .ibuf_rs1     (ibuf_rs1),
        .ibuf_rs2     (ibuf_rs2),
        .ibuf_rs3     (ibuf_rs3),
        .ibuf_payload (ibuf_payload),
        .ibuf_ready   (ibuf_ready),
        .wb_valid     (wb_valid),
        .wb_wis       (wb_wis),
        .wb_rd        (wb_rd),
        .wb_eop       (wb_eop),
        .sb_valid     (sb_valid),
        .sb_wis       (sb_wis),
        .sb_wb        (sb_wb),
        .sb_rd        (sb_rd),
        .sb_rs1       (sb_rs1),
        .sb_rs2       (sb_rs2),
        .sb_rs3       (sb_rs3),
        .sb_payload   (sb_payload),
        .sb_ready     (sb_ready)
`ifdef VX_SCOREBOARD_PERF_EN
        ,
        .perf_stalls  (perf_stalls)
`endif
    );

    typedef struct {
        logic       v;
        logic [1:0] wis;
        logic       wb;
        logic [5:0] rd;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [5:0] rs3;
        logic       wbv;
        logic [1:0] wwis;
        logic [5:0] wrd;
        logic       eop;
        logic       sbr;
        logic       exp_rdy;
        logic       exp_sbv;
    } vec_t;

    typedef struct {
        logic [1:0]   wis;
        logic         wb;
        logic [5:0]   rd;
        logic [5:0]   rs1;
        logic [5:0]   rs2;
        logic [5:0]   rs3;
        logic [127:0] payload;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [159:0] a,
                       input logic [159:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    function automatic vec_t mk(input int v, input int wis, input int wb,
                                input int rd, input int rs1, input int rs2,
                                input int rs3, input int wbv, input int wwis,
                                input int wrd, input int eop, input int sbr,
                                input int er, input int es);
        vec_t r;
        r.v = 1'(v);       r.wis = 2'(wis);   r.wb = 1'(wb);
        r.rd = 6'(rd);     r.rs1 = 6'(rs1);   r.rs2 = 6'(rs2);
        r.rs3 = 6'(rs3);   r.wbv = 1'(wbv);   r.wwis = 2'(wwis);
        r.wrd = 6'(wrd);   r.eop = 1'(eop);   r.sbr = 1'(sbr);
        r.exp_rdy = 1'(er); r.exp_sbv = 1'(es);
        return r;
    endfunction

    task automatic drive(input vec_t t, input logic [127:0] pl);
        ibuf_valid   = t.v;
        ibuf_wis     = t.wis;
        ibuf_wb      = t.wb;
        ibuf_rd      = t.rd;
        ibuf_rs1     = t.rs1;
        ibuf_rs2     = t.rs2;
        ibuf_rs3     = t.rs3;
        ibuf_payload = pl;
        wb_valid     = t.wbv;
        wb_wis       = t.wwis;
        wb_rd        = t.wrd;
        wb_eop       = t.eop;
        sb_ready     = t.sbr;
    endtask

    // Scoreboard: accepted instructions queued, checked while on the output.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            chk("sb_valid_vs_queue", 160'(sb_valid), 160'(q.size() != 0));
            if (sb_valid && q.size() != 0) begin
                chk("sb_out",
                    {sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_payload},
                    {q[0].wis, q[0].wb, q[0].rd, q[0].rs1, q[0].rs2,
                     q[0].rs3, q[0].payload});
                if (sb_ready) void'(q.pop_front());
            end
            if (ibuf_valid && ibuf_ready) begin
                q.push_back('{ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1,
                              ibuf_rs2, ibuf_rs3, ibuf_payload});
            end
        end
    end

    initial begin
        vec_t idle;
        logic [127:0] pl;
        idle = mk(0,0,0,0,0,0,0, 0,0,0,0, 1, 0,0);

        // RAW on w0 r5, released by a final writeback
        tbl.push_back(mk(1,0,1,5,0,0,0,   0,0,0,0, 1, 1,0));
        tbl.push_back(mk(1,0,0,0,5,0,0,   0,0,0,0, 1, 0,1));
        tbl.push_back(mk(1,0,0,0,5,0,0,   0,0,0,0, 1, 0,0));
        tbl.push_back(mk(1,0,0,0,5,0,0,   1,0,5,1, 1, 0,0));
        tbl.push_back(mk(1,0,0,0,5,0,0,   0,0,0,0, 1, 1,0));
        // warp independence
        tbl.push_back(mk(1,0,1,5,0,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(1,1,0,0,5,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,   1,0,5,1, 1, 1,1));
        // WAW on w2 r7, eop=0 beat does not release
        tbl.push_back(mk(1,2,1,7,0,0,0,   0,0,0,0, 1, 1,0));
        tbl.push_back(mk(1,2,1,7,0,0,0,   0,0,0,0, 1, 0,1));
        tbl.push_back(mk(1,2,1,7,0,0,0,   1,2,7,0, 1, 0,0));
        tbl.push_back(mk(1,2,1,7,0,0,0,   0,0,0,0, 1, 0,0));
        tbl.push_back(mk(1,2,1,7,0,0,0,   1,2,7,1, 1, 0,0));
        tbl.push_back(mk(1,2,1,7,0,0,0,   0,0,0,0, 1, 1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,   1,2,7,1, 1, 1,1));
        // r0 never busy
        tbl.push_back(mk(1,3,1,0,0,0,0,   0,0,0,0, 1, 1,0));
        tbl.push_back(mk(1,3,0,0,0,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(1,3,1,0,0,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,0,0, 1, 1,1));
        // backpressure for 3 cycles, then back-to-back issue
        tbl.push_back(mk(1,1,0,0,0,0,0,   0,0,0,0, 0, 1,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,   0,0,0,0, 0, 0,1));
        tbl.push_back(mk(1,1,0,0,0,0,0,   0,0,0,0, 0, 0,1));
        tbl.push_back(mk(1,1,0,0,0,0,0,   0,0,0,0, 0, 0,1));
        tbl.push_back(mk(1,1,0,0,0,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(1,2,0,0,3,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(1,3,1,9,4,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(1,0,1,9,1,0,0,   0,0,0,0, 1, 1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,   1,3,9,1, 1, 1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,   1,0,9,1, 1, 1,0));
        // RAW through rs2 and rs3
        tbl.push_back(mk(1,0,1,12,0,0,0,  0,0,0,0, 1, 1,0));
        tbl.push_back(mk(1,0,0,0,0,12,0,  0,0,0,0, 1, 0,1));
        tbl.push_back(mk(1,0,0,0,0,0,12,  0,0,0,0, 1, 0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,   1,0,12,1, 1, 1,0));

        reset = 1'b1;
        drive(idle, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_sb_valid", 160'(sb_valid), 160'(0));
        chk("rst_sb_data",
            {sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_payload}, '0);
        chk("rst_ibuf_ready", 160'(ibuf_ready), 160'(1));

        foreach (tbl[i]) begin
            @(posedge clk);
            pl = {32'(i), 32'hDEAD_BEEF, ~32'(i), 32'h1234_5678};
            #1 drive(tbl[i], pl);
            @(negedge clk);
            chk($sformatf("v%0d_ibuf_ready", i),
                160'(ibuf_ready), 160'(tbl[i].exp_rdy));
            chk($sformatf("v%0d_sb_valid", i),
                160'(sb_valid), 160'(tbl[i].exp_sbv));
        end

        // reset while an instruction is held on the output
        @(posedge clk);
        #1 drive(mk(1,0,1,20,0,0,0, 0,0,0,0, 0, 0,0), 128'hAAAA_0020);
        @(negedge clk);
        chk("mid_fire_ready", 160'(ibuf_ready), 160'(1));
        @(posedge clk);
        #1 begin
            drive(idle, '0);
            sb_ready = 1'b0;
            reset = 1'b1;
        end
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            drive(mk(1,0,0,0,20,0,0, 0,0,0,0, 1, 0,0), 128'hBBBB_0020);
        end
        @(negedge clk);
        chk("mid_rst_sb_valid", 160'(sb_valid), 160'(0));
        chk("mid_rst_sb_data",
            {sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_payload}, '0);
        chk("mid_rst_busy_clear", 160'(ibuf_ready), 160'(1));
        @(posedge clk);
        #1 drive(idle, '0);
        @(posedge clk);

`ifdef VX_SCOREBOARD_PERF_EN
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("perf_after_reset", 160'(perf_stalls), 160'(0));
        @(posedge clk);
        #1 drive(mk(1,0,1,20,0,0,0, 0,0,0,0, 1, 0,0), 128'hCCCC_0020);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 drive(mk(1,0,0,0,20,0,0, 0,0,0,0, 1, 0,0), 128'hDDDD_0020);
            @(negedge clk);
            chk("perf_stall_ready", 160'(ibuf_ready), 160'(0));
        end
        @(posedge clk);
        #1 drive(idle, '0);
        @(negedge clk);
        chk("perf_ten", 160'(perf_stalls), 160'(10));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("perf_cleared", 160'(perf_stalls), 160'(0));
        @(posedge clk);
`endif

        @(negedge clk);
        chk("queue_drained", 160'(q.size()), 160'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_issue_scoreboard.md
Name: vx_issue_scoreboard

Overview:
- Producer (master) side of the scoreboard-to-operand handshake: accepts decoded instructions from the instruction buffer and forwards them to operand collection only when free of register hazards.
- Tracks in-flight destination registers per issue warp in a busy table.
- Set on issue, cleared on final writeback.
- Sits between the ibuffer and the operand/dispatch stage within one issue slice.

Parameters:
- NUM_WARPS, 4, issue warps in this slice; WIS_W = max(1, clog2(NUM_WARPS)).
- NUM_REGS, 64, architectural registers per warp; NR_W = clog2(NUM_REGS).
- PAYLOAD_W, 128, opaque pass-through bits (uuid, tmask, PC, ex/op type, op args).
- PERF_W, 44, stall counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ibuf_valid  in  1  instruction present
- ibuf_wis  in  WIS_W  warp index
- ibuf_wb  in  1  instruction writes rd
- ibuf_rd / ibuf_rs1 / ibuf_rs2 / ibuf_rs3  in  NR_W each  register indices
- ibuf_payload  in  PAYLOAD_W  pass-through
- ibuf_ready  out  1  instruction accepted when valid&ready
- wb_valid  in  1  writeback beat
- wb_wis  in  WIS_W  writeback warp
- wb_rd  in  NR_W  writeback register
- wb_eop  in  1  last beat of that writeback
- sb_valid  out  1  hazard-free instruction available
- sb_wis, sb_wb, sb_rd, sb_rs1, sb_rs2, sb_rs3, sb_payload  out  as input widths  registered copy of accepted instruction
- sb_ready  in  1  consumer accepts
- perf_stalls  out  PERF_W  hazard-stall cycles (only with VX_SCOREBOARD_PERF_EN)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- Reset values: busy table all 0; sb_valid 0; all sb_* data 0; perf_stalls 0. ibuf_ready may be 1 the cycle after reset deasserts.
- Busy table: NUM_WARPS x NUM_REGS bits.
- Hazard: asserted when ibuf_valid is high and any of the following is busy in busy[ibuf_wis]:
  - rs1, rs2 or rs3 (RAW);
  - rd, when ibuf_wb=1 (WAW).
  - Register 0 is never busy and never set.
- Hazard evaluation uses the registered table only: no same-cycle bypass of a wb clear. Result is one cycle later than ideal; this is required.
- ibuf_ready = !hazard && (!sb_valid || sb_ready). It is combinational from the inputs and the table; there is no combinational path from ibuf_valid to ibuf_ready except through hazard.
- Input fire (ibuf_valid && ibuf_ready):
  - Load the output register and set sb_valid=1. Latency is exactly 1 cycle.
  - If ibuf_wb and rd != 0, set busy[wis][rd] in the same edge. The next instruction sees it as busy immediately.
- Output: sb_valid && !sb_ready holds every sb_* signal stable. sb_valid && sb_ready with no new fire clears sb_valid. Fire and output handshake in the same cycle give back-to-back issue at 1 instr/cycle.
- Writeback: wb_valid && wb_eop clears busy[wb_wis][wb_rd] at the edge. Beats with wb_eop=0 have no effect.
- Set and clear of the same bit in the same cycle: unreachable, because a set requires the bit not busy. If it occurs anyway, set wins.
- Clearing a non-busy bit is a no-op. A simulation-only assertion flags it.
- Multiple warps are independent. A hazard on warp A blocks only the instruction currently presented; there is no internal reordering (single input port, in-order).
- Reset mid-operation: all busy bits and any held output are dropped at the reset edge. Upstream must also flush.

Optional Feature:
- Macro VX_SCOREBOARD_PERF_EN.
- Defined: perf_stalls port exists. It increments by 1 every cycle in which ibuf_valid && hazard, saturating at all-ones, and resets to 0.
- Undefined: the port and counter are absent. No other behaviour changes.

Test Plan:
- Issue w0 "wb rd=5" then, next cycle, w0 "rs1=5" -> second stalls (ibuf_ready=0) until wb_valid=1, wb_eop=1, wis=0, rd=5; it issues on the cycle after the clear.
- w0 "wb rd=5" busy, then w1 "rs1=5" -> no stall; sb_valid the next cycle with sb_wis=1.
- w2 "wb rd=7", then w2 "wb rd=7" with no reads -> WAW stall until rd 7 is cleared. A wb beat with eop=0 does not release it.
- "wb rd=0" followed by "rs1=0" -> no stall; busy table stays all-zero.
- sb_ready held 0 for 3 cycles with sb_valid=1 -> sb_* stable and ibuf_ready=0. Then sb_ready=1 with continuous hazard-free input -> one instruction per cycle.
- With VX_SCOREBOARD_PERF_EN: 10 hazard cycles then reset -> perf_stalls=10, then 0 after reset. Assert reset while sb_valid=1 -> sb_valid=0 and busy table cleared next cycle.
